signal_debounce: RTL and testbench

SIGNAL_DEBOUNCE -- requirements
Module: signal_debounce

---
 rtl/signal_debounce.sv | 106 ++++++++++
 tb/tb_signal_debounce.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/signal_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : signal_debounce
//  Description : Two-flop synchronizer followed by an IDLE/CHECK debounce FSM.
//                dout follows din once a changed level has been observed on
//                the synchronized input for DEBOUNCE_CYCLES consecutive
//                cycles. Shorter mismatch runs are rejected and, when the
//                DEBOUNCE_GLITCH_CNT_EN macro is defined, counted in a
//                saturating 8-bit glitch counter (tied to zero otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module signal_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       dout,
    output logic       stable,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CHECK = 1'b1
    } state_t;

    // r_cnt holds how many consecutive mismatch cycles have already been
    // observed. The edge that sees the DEBOUNCE_CYCLES-th mismatch commits
    // the new level, so the commit happens when r_cnt has reached N-1.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_dout;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;

    // Synchronizer chain and debounce state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dout  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            case (r_state)
                S_IDLE: begin
                    if (r_sync2 != r_dout) begin
                        r_cnt   <= c_cnt_one;
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                S_CHECK: begin
                    if (r_sync2 == r_dout) begin
                        // Input bounced back before qualifying
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (r_cnt >= c_cnt_last) begin
                        r_dout  <= r_sync2;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       w_glitch;
    logic [7:0] r_glitch_cnt;

    assign w_glitch = (r_state == S_CHECK) && (r_sync2 == r_dout);

    // Saturating count of rejected candidate changes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    assign glitch_cnt = 8'd0;
`endif

    assign dout   = r_dout;
    assign stable = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_signal_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signal_debounce
//  Description : Directed self-checking bench for signal_debounce with
//                DEBOUNCE_CYCLES = 4. Covers reset, clean rise/fall latency,
//                short-pulse rejection, glitch counter saturation and reset
//                in the middle of a qualification window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_debounce;

    localparam int N = 4;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam bit c_gc_en = 1'b1;
`else
    localparam bit c_gc_en = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       din;
    logic       dout;
    logic       stable;
    logic [7:0] glitch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    signal_debounce #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dout      (dout),
        .stable    (stable),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs can be sampled
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gexp(input int n);
        return c_gc_en ? 8'(n) : 8'd0;
    endfunction

    initial begin
        rst = 1'b1;
        din = 1'b0;
        #1;

        // Reset held three cycles while din toggles
        for (int i = 0; i < 3; i++) begin
            din = (i % 2 == 0);
            step();
            check("rst_dout",   {7'd0, dout},   8'd0);
            check("rst_stable", {7'd0, stable}, 8'd1);
            check("rst_glitch", glitch_cnt,     8'd0);
        end
        rst = 1'b0;
        din = 1'b0;
        step();
        check("post_rst_dout",   {7'd0, dout},   8'd0);
        check("post_rst_stable", {7'd0, stable}, 8'd1);
        check("post_rst_glitch", glitch_cnt,     8'd0);

        // Clean rise: edge j=0 is the sync1 capture edge, dout rises at j=5
        din = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            step();
            check($sformatf("rise_stable_e%0d", j), {7'd0, stable},
                  ((j >= 2) && (j <= 4)) ? 8'd0 : 8'd1);
            check($sformatf("rise_dout_e%0d", j), {7'd0, dout},
                  (j == 5) ? 8'd1 : 8'd0);
        end
        check("rise_glitch", glitch_cnt, 8'd0);

        // Clean fall with the same latency
        din = 1'b0;
        for (int j = 0; j <= 5; j++) begin
            step();
            check($sformatf("fall_dout_e%0d", j), {7'd0, dout},
                  (j == 5) ? 8'd0 : 8'd1);
        end
        check("fall_stable", {7'd0, stable}, 8'd1);
        check("fall_glitch", glitch_cnt,     8'd0);

        // Three-cycle high pulse: three mismatch observations, then rejected
        din = 1'b1;
        step(); step(); step();
        din = 1'b0;
        step();
        step();
        check("pulse_stable_mid", {7'd0, stable}, 8'd0);
        step();
        check("pulse_dout",   {7'd0, dout},   8'd0);
        check("pulse_stable", {7'd0, stable}, 8'd1);
        check("pulse_glitch", glitch_cnt,     gexp(1));

        // Repeated bounces drive the glitch counter to saturation
        for (int b = 0; b < 253; b++) begin
            din = 1'b1;
            step(); step(); step();
            din = 1'b0;
            step(); step(); step(); step();
        end
        check("bounce_glitch_254", glitch_cnt,     gexp(254));
        check("bounce_dout_254",   {7'd0, dout},   8'd0);
        for (int b = 0; b < 47; b++) begin
            din = 1'b1;
            step(); step(); step();
            din = 1'b0;
            step(); step(); step(); step();
        end
        check("bounce_glitch_sat", glitch_cnt,     gexp(255));
        check("bounce_dout",       {7'd0, dout},   8'd0);
        check("bounce_stable",     {7'd0, stable}, 8'd1);

        // Reset asserted on the edge where dout would have risen
        din = 1'b1;
        for (int j = 0; j <= 4; j++) begin
            step();
        end
        check("midchk_stable", {7'd0, stable}, 8'd0);
        check("midchk_dout",   {7'd0, dout},   8'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_dout",   {7'd0, dout},   8'd0);
        check("midrst_stable", {7'd0, stable}, 8'd1);
        check("midrst_glitch", glitch_cnt,     8'd0);
        for (int j = 1; j <= 6; j++) begin
            step();
            check($sformatf("rerise_dout_e%0d", j), {7'd0, dout},
                  (j == 6) ? 8'd1 : 8'd0);
        end
        check("rerise_glitch", glitch_cnt, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
